// File: rtl/fetch_pkg.sv
// Shared widths and packet helpers for the buffered fetch stage.
// A packet carries the instruction in its upper bits and the fetch PC in its lower bits.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;
    localparam int FETCH_DEPTH   = 4;
    localparam int FETCH_PKT_W   = FETCH_INSTR_W + FETCH_ADDR_W;

    function automatic logic [FETCH_PKT_W-1:0] pack_packet(
        input logic [FETCH_INSTR_W-1:0] instr,
        input logic [FETCH_ADDR_W-1:0]  pc
    );
        return {instr, pc};
    endfunction

    function automatic logic [FETCH_INSTR_W-1:0] unpack_instr(input logic [FETCH_PKT_W-1:0] pkt);
        return pkt[FETCH_PKT_W-1:FETCH_ADDR_W];
    endfunction

    function automatic logic [FETCH_ADDR_W-1:0] unpack_pc(input logic [FETCH_PKT_W-1:0] pkt);
        return pkt[FETCH_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from registered storage.
// Power-of-two depth lets the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Flush also clears storage so nothing from before a redirect can reach the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit_buffered.sv
// Decoupled fetch stage: issues reads to a one-cycle instruction memory and buffers
// returned instructions with their PCs; a redirect flushes everything buffered or in flight.
module fetch_unit_buffered
    import fetch_pkg::*;
#(
    parameter int                  ADDR_W   = FETCH_ADDR_W,
    parameter int                  INSTR_W  = FETCH_INSTR_W,
    parameter int                  DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    output logic                        if_valid,
    input  logic                        if_ready,
    output logic [INSTR_W+ADDR_W-1:0]   if_output,
    output logic [$clog2(DEPTH):0]      if_count
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    credit;

    assign pop    = if_valid && if_ready && !redirect_valid;
    assign push   = inflight && !redirect_valid;
    // Slots already claimed once this cycle's pop retires; the in-flight word counts as claimed.
    assign credit = {1'b0, if_count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign issue  = !redirect_valid && (credit < DEPTH_L);

    assign imem_req  = issue && !rst;
    assign imem_addr = fetch_pc;
    assign if_valid  = (if_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 1'b1;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({imem_rdata, inflight_pc}),
        .pop       (pop),
        .head      (if_output),
        .count     (if_count)
    );

endmodule

// File: doc/fetch_unit_buffered.md
# fetch_unit_buffered

Parametrised, decoupled instruction fetch stage. Drives a synchronous-read instruction memory (one-cycle read latency) and stores returned instructions with their addresses in a small prefetch FIFO. The FIFO feeds decode through a valid/ready handshake. Branch redirects from execute flush all buffered and in-flight fetches. The unit sits between the execution unit's branch-update path and the decode stage.

## Interface
Parameters:
- ADDR_W, 8: PC/instruction-address width; word-addressed, PC increments by 1.
- INSTR_W, 16: instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 0: PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch taken; load redirect_pc and flush.
- redirect_pc  in  ADDR_W  branch target.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address; equals fetch PC.
- imem_rdata  in  INSTR_W  read data, valid the cycle after a cycle with imem_req=1.
- if_valid  out  1  FIFO head holds a valid packet.
- if_ready  in  1  decode accepts the head.
- if_output  out  INSTR_W+ADDR_W  head packet: instruction in [INSTR_W+ADDR_W-1:ADDR_W], its PC in [ADDR_W-1:0].
- if_count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- State:
  - fetch_pc.
  - inflight flag and inflight_pc: one request is outstanding.
  - FIFO storage, read pointer, write pointer, occupancy.
- Pop: if_valid && if_ready && !redirect_valid.
- Issue condition: !redirect_valid && (occupancy + inflight − pop) < DEPTH.
  - imem_req equals the issue condition.
  - imem_addr = fetch_pc.
  - The issue condition is combinational from if_ready; accepted path.
- On issue:
  - fetch_pc ← fetch_pc+1, wrapping modulo 2^ADDR_W (0xFF→0x00 at ADDR_W=8).
  - inflight ← 1.
  - inflight_pc ← fetch_pc.
- No issue: inflight ← 0.
- Push: when inflight=1 and no redirect, write {imem_rdata, inflight_pc} at the write pointer.
- Redirect priority: highest. In the redirect cycle:
  - fetch_pc ← redirect_pc.
  - FIFO emptied, pointers zeroed.
  - inflight ← 0; the returning data is discarded.
  - No pop occurs, even if if_ready=1.
  - imem_req=0.
- Overflow cannot occur: the credit check guarantees push never targets a full FIFO. The bench asserts this.
- Push and pop in the same cycle leave occupancy unchanged. Pop on empty is impossible because if_valid=0.
- if_valid = (occupancy ≠ 0). if_output is the head entry, registered storage, with no combinational path from imem_rdata.

## Timing
- Reset values:
  - imem_req 0.
  - imem_addr RESET_PC.
  - if_valid 0.
  - if_output 0.
  - if_count 0.
  - inflight 0.
  - fetch_pc RESET_PC.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Request-to-if_valid latency: 2 cycles. Request in cycle n, data in n+1, written at end of n+1, if_valid in n+2.
- Redirect-to-first-valid: redirect in cycle n, request to target in n+1, if_valid in n+3.
- Throughput: 1 instruction/cycle with if_ready held high, for any DEPTH≥2.
- Backpressure: with if_ready=0, the FIFO fills to DEPTH, then imem_req stays 0. Head data is stable while if_valid=1 and if_ready=0.
- rst asserted mid-operation: immediate clear of all state. The pending memory response is ignored.

## Structure
- Package fetch_pkg holds:
  - default widths.
  - packet type/width constant FETCH_PKT_W = INSTR_W+ADDR_W.
  - pack/unpack functions.
- Sub-module fetch_fifo: parametrised synchronous FIFO with push, pop, flush, count, head, and async reset. The top holds the PC, inflight tracking and the credit logic.

## Test plan
- Reset then free run, if_ready=1, memory word k = 0x1000+k:
  - if_output sequence {0x1000,0x00}, {0x1001,0x01}, … one per cycle from cycle 2.
- Redirect to 0x04 while 2 entries are buffered and one is in flight:
  - next valid packet is {0x1004,0x04}, 3 cycles after the redirect.
  - no stale PC ever appears on if_output.
- if_ready=0 for 10 cycles:
  - if_count saturates at DEPTH (4).
  - imem_req is 0 from the cycle after saturation.
  - the head stays {0x1000,0x00}.
  - on release, the sequence resumes in order with no loss or duplication.
- Redirect to 0xFE, free run:
  - PCs 0xFE, 0xFF, 0x00, 0x01 (wrap).
- rst pulse while 3 entries are buffered:
  - if_valid 0 and if_count 0 in the same cycle.
  - after release, fetch restarts at RESET_PC.
- Redirect in the same cycle as if_valid&&if_ready:
  - no pop is counted.
  - the FIFO is flushed.
  - if_count 0 next cycle.
